// File: rtl/tone_square_gen.sv
// tone_square_gen
// Square-wave tone generator driven by a decoded note frequency in Hz.
// An accumulate-and-subtract fractional divider adds 2*f every clock and
// toggles the output whenever the running sum crosses CLK_HZ. The leftover
// remainder is carried forward, so the long-run toggle rate is exactly 2*f
// per second with no drift and no divider hardware. New frequencies and stop
// requests are only accepted on the falling edge of audio (period boundary).
// This keeps every period whole and glitch-free.

module tone_square_gen #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int          ACC_W  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] freq,
   input  logic        en,
   output logic        audio,
   output logic        busy,
   output logic        toggle_stb
);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   // CLK_HZ at the wide sum width for the wrap compare. It is also kept at
   // accumulator width for the subtraction. The true remainder always fits in
   // ACC_W bits, so the narrow subtract is exact.
   localparam logic [ACC_W+1:0] CLK_WIDE = (ACC_W+2)'(CLK_HZ);
   localparam logic [ACC_W-1:0] CLK_ACC  = ACC_W'(CLK_HZ);
   localparam logic [31:0]      HALF_HZ  = 32'(CLK_HZ / 2);

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [31:0]      active_freq;
   logic [31:0]      active_freq_next;
   logic             audio_next;
   logic             busy_next;
   logic             toggle_stb_next;

   logic             valid_req;
   logic [ACC_W+1:0] sum;
   logic             wrap;
   logic [ACC_W-1:0] acc_wrapped;

   // A request counts only when enabled and strictly inside (0, CLK_HZ/2).
   // Anything else is silence. The sum is two bits wider than acc so that
   // acc + 2*f can never overflow before it is compared against CLK_HZ.
   always_comb begin
      valid_req   = en && (freq != 32'd0) && (freq < HALF_HZ);
      sum         = {2'b00, acc} + (ACC_W+2)'({active_freq, 1'b0});
      wrap        = (sum >= CLK_WIDE);
      acc_wrapped = sum[ACC_W-1:0] - CLK_ACC;
   end

   // Next-state logic: idle waits for a request. Play accumulates and toggles.
   // At the falling edge it either reloads the frequency or returns to idle.
   always_comb begin
      state_next       = state;
      acc_next         = acc;
      active_freq_next = active_freq;
      audio_next       = audio;
      toggle_stb_next  = 1'b0;

      case (state)
         IDLE: begin
            audio_next = 1'b0;
            acc_next   = '0;
            if (valid_req) begin
               active_freq_next = freq;
               state_next       = PLAY;
            end
         end

         PLAY: begin
            if (wrap) begin
               acc_next        = acc_wrapped;
               audio_next      = ~audio;
               toggle_stb_next = 1'b1;
               if (audio) begin
                  if (valid_req) begin
                     active_freq_next = freq;
                  end else begin
                     state_next = IDLE;
                     acc_next   = '0;
                  end
               end
            end else begin
               acc_next = sum[ACC_W-1:0];
            end
         end

         default: begin
            state_next = IDLE;
            acc_next   = '0;
            audio_next = 1'b0;
         end
      endcase

      busy_next = (state_next == PLAY);
   end

   // All state and outputs are registered. A synchronous reset silences the
   // output on the next edge, whatever the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         active_freq <= 32'd0;
         audio       <= 1'b0;
         busy        <= 1'b0;
         toggle_stb  <= 1'b0;
      end else begin
         state       <= state_next;
         acc         <= acc_next;
         active_freq <= active_freq_next;
         audio       <= audio_next;
         busy        <= busy_next;
         toggle_stb  <= toggle_stb_next;
      end
   end

endmodule

// File: doc/tone_square_gen.md
# tone_square_gen

Square-wave tone generator that sits directly downstream of the key-to-frequency decoder. It consumes the decoded 32-bit note frequency in Hz and drives a 1-bit audio output at exactly that frequency, averaged over time, using an accumulate-and-subtract fractional divider. The divider needs no division hardware. Frequency changes and silencing take effect only at period boundaries, so the output never glitches.

## Interface
- CLK_HZ, default 50000000: system clock frequency in Hz; must fit in ACC_W bits.
- ACC_W, default 32: accumulator width.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- freq  in  32  note frequency in Hz from the decoder; 0 = no key pressed
- en  in  1  play enable; en=0 is treated exactly as freq=0
- audio  out  1  square-wave output, registered
- busy  out  1  high while in PLAY, registered
- toggle_stb  out  1  one-cycle pulse in the same cycle audio changes value, registered

## Operation
- **Valid request:** en=1 and 0 < freq < CLK_HZ/2. Any other freq, including out-of-range values, is treated as silence.
- **Registers:**
  - state: IDLE or PLAY.
  - acc: ACC_W bits; invariant acc < CLK_HZ.
  - active_freq: 32 bits.
  - audio, busy, toggle_stb.
- **IDLE:**
  - audio=0, acc=0, busy=0.
  - On a valid request: active_freq←freq, acc←0, state←PLAY.
- **PLAY:** each cycle, sum = acc + 2·active_freq, computed at ACC_W+2 bits with no truncation.
  - If sum ≥ CLK_HZ: acc←sum−CLK_HZ, audio←~audio, toggle_stb←1.
  - Otherwise: acc←sum, toggle_stb←0.
- **Period boundary:** a toggle cycle in which audio goes 1→0.
  - If a valid request is present: active_freq←freq and stay in PLAY. acc carries its remainder forward and is not cleared.
  - Otherwise: state←IDLE, acc←0. audio is already 0.
- **Mid-period inputs:** freq and en changes between boundaries are ignored. active_freq is never updated mid-period.
- busy = (state==PLAY), registered.

## Timing
- **Reset values:** state=IDLE, acc=0, active_freq=0, audio=0, busy=0, toggle_stb=0. Reset applies at the next rising edge.
- **Reset mid-PLAY:** silences audio in the cycle after rst is sampled. No partial period completes.
- **Start latency:** a valid request sampled in IDLE at edge N gives busy=1 after edge N. The first PLAY sum is evaluated in the following cycle.
- **First edge:** audio rises after ceil(CLK_HZ/(2·f)) PLAY cycles. toggle_stb is high for exactly the cycle in which audio shows the new value.
- **Exact average:** over any window of CLK_HZ PLAY cycles at fixed f, exactly 2·f toggles occur, with no cumulative drift. Individual half-periods differ by at most 1 cycle.
- **Duty cycle:** 50% ±1 cycle per half-period.
- **Stopping:** a stop (freq=0 or en=0) presented during the high half lets audio stay 1 until the falling edge, then returns to IDLE. A stop presented during the low half keeps playing until the next falling edge, i.e. the current period always completes.
- **Simultaneous rst and request:** rst wins.
- **Back-to-back requests:** a valid request present in the boundary cycle continues with no idle gap.

## Test plan
Directed scenarios below use CLK_HZ=1000.

1. **Basic tone:** freq=100, en=1 from IDLE → busy=1 next cycle.
   - audio rises 5 PLAY cycles later, falls 5 cycles after that; period 10 cycles.
   - toggle_stb is a single-cycle pulse at each edge.
2. **Change at boundary:** freq switched 100→250 while audio=1 → the current period finishes at 10 cycles. The subsequent periods are 4 cycles (step 500, toggle every 2 cycles).
3. **Stop during high half:** freq→0 while audio=1 → audio holds 1 until its scheduled fall, then IDLE. busy=0 and audio=0 thereafter. en→0 gives the identical response.
4. **Range boundary:**
   - freq=500 and freq=600 → remain IDLE, audio=0, busy=0.
   - freq=499 → PLAY, toggling every 1–2 cycles.
5. **No drift:** freq=130 held for exactly 1000 PLAY cycles → exactly 260 toggle_stb pulses. Every half-period is 3 or 4 cycles.
6. **Reset mid-play:** rst pulsed during PLAY with freq=100 held → next cycle audio=0, busy=0, toggle_stb=0. After release, the scenario 1 timing repeats exactly.
